serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial stimulus transmitter producing the single-bit `w` stream consumed by the team's serial sequence-detector FSMs. Accepts a parallel word over a load/ready handshake and shifts it out one bit per clock, then holds a programmable idle gap before accepting the next word. Sits upstream of the detector, either on-chip as a pattern source or in the lab harness driving the detector's `w` input on the same `Clock`.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `GAP`, default 2: idle cycles inserted after each word; legal range 0..15.
- `LSB_FIRST`, default 0: 0 = MSB first, 1 = LSB first.

- `Clock`  input  1  single clock; all state updates on the rising edge.
- `Resetn`  input  1  asynchronous, active-low reset.
- `data_in`  input  WIDTH  word to transmit; sampled only on an accepted load.
- `load`  input  1  request to transmit `data_in`.
- `ready`  output  1  high when a load is accepted this cycle.
- `w`  output  1  serial data bit; 0 whenever `w_valid` is 0.
- `w_valid`  output  1  high while `w` carries a word bit.
- `done`  output  1  one-cycle pulse coinciding with the last bit of a word.

## Operation
- States: IDLE, SHIFT, GAP.
- `ready` = (state == IDLE), decoded from the state register; `w`, `w_valid`, `done` are registered.
- IDLE: on `load && ready` capture `data_in` into shift register, load bit counter with WIDTH-1, go to SHIFT. `load` low: stay in IDLE.
- SHIFT: present current head bit on `w` with `w_valid`=1; shift toward head each cycle; decrement counter. When the counter reaches 0, the bit presented is the last one: `done`=1 for that cycle. Next state GAP if GAP>0, else IDLE.
- GAP: `w`=0, `w_valid`=0, `ready`=0 for exactly GAP cycles (gap counter width 4), then IDLE.
- `load` outside IDLE is ignored; `data_in` changes outside an accepted load have no effect.
- Head bit: `data_in[WIDTH-1]` when LSB_FIRST=0, `data_in[0]` when LSB_FIRST=1.
- Bit counter width: smallest width holding WIDTH-1; no wrap-around reachable.
- Reset (any state, any time): state IDLE, shift register 0, counters 0, `w`=0, `w_valid`=0, `done`=0, so `ready`=1. A word in flight is dropped; no partial `done`.

## Timing
- Cycle 0: `load` sampled high with `ready`=1.
- Cycles 1..WIDTH: word bits on `w`, `w_valid`=1; `done`=1 in cycle WIDTH only.
- Cycles WIDTH+1..WIDTH+GAP: gap, all outputs low.
- Cycle WIDTH+GAP+1: `ready`=1; with `load` held high the next word's first bit appears in cycle WIDTH+GAP+2.
- Throughput: one word per WIDTH+GAP+1 cycles; latency load-to-first-bit = 1 cycle.
- GAP=0: SHIFT returns directly to IDLE; one idle cycle between words is still guaranteed (`w_valid`=0 in that cycle).
- Resetn deassertion is asynchronous to `Clock`; first legal load at the first rising edge after deassertion.

## Test plan
- Reset: assert Resetn low mid-run -> `w`=0, `w_valid`=0, `done`=0, `ready`=1 immediately, without waiting for a clock edge.
- Single word, WIDTH=8, GAP=2, MSB first, `data_in`=8'hA5 -> `w` = 1,0,1,0,0,1,0,1 in cycles 1..8, `done` only in cycle 8, `ready` back high in cycle 11.
- LSB_FIRST=1, `data_in`=8'h01 -> `w` = 1 in cycle 1, then 0 for cycles 2..8.
- Load while busy: second load with `data_in`=8'hFF pulsed in cycle 4 -> ignored, stream stays 8'hA5, no extra `done`.
- Back-to-back, GAP=0, `load` held high, words 8'hC3 then 8'h3C -> bits in cycles 1..8, idle cycle 9, second word in cycles 10..17, `done` in cycles 8 and 17.
- Reset mid-word: Resetn low during cycle 4 of 8'hA5 -> outputs clear at once, no `done`; new load after release transmits correctly from its first bit.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Purpose: shifts a parallel word out on w, one bit per Clock, then holds a fixed idle gap.
// Latency: first bit on w one cycle after an accepted load; one word every WIDTH+GAP+1 cycles.
// Backpressure: ready is high only in IDLE; load outside IDLE is ignored and never queued.
module serial_pattern_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 2,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             done
);

    // Bit counter holds the number of bits still to send after the one on w.
    localparam int                CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     CNT_LD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    // Gap counter counts down the remaining gap cycles after the current one.
    localparam logic [3:0]        GAP_LD = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_nxt;
    logic [3:0]       gap_cnt;
    logic [3:0]       gap_cnt_nxt;
    logic             w_nxt;
    logic             w_valid_nxt;
    logic             done_nxt;
    logic             accept;

    // Bit that goes out next, taken from the head end of a word.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    // Moves the following bit into the head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    assign ready  = (state == S_IDLE);
    assign accept = load && ready;

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: IDLE -> SHIFT on accept, SHIFT drains, GAP counts out.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt == '0) begin
                    state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath decode; w/w_valid/done are computed one cycle ahead and registered.
    always_comb begin
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        w_nxt       = 1'b0;
        w_valid_nxt = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    // First bit leaves straight from data_in; the rest waits in shreg.
                    w_nxt       = head_bit(data_in);
                    w_valid_nxt = 1'b1;
                    shreg_nxt   = advance(data_in);
                    bit_cnt_nxt = CNT_LD;
                end
            end
            S_SHIFT: begin
                if (bit_cnt != '0) begin
                    w_nxt       = head_bit(shreg);
                    w_valid_nxt = 1'b1;
                    shreg_nxt   = advance(shreg);
                    bit_cnt_nxt = bit_cnt - CNT_ONE;
                    done_nxt    = (bit_cnt == CNT_ONE);
                end else begin
                    gap_cnt_nxt = GAP_LD;
                end
            end
            S_GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                shreg_nxt   = '0;
                bit_cnt_nxt = '0;
                gap_cnt_nxt = '0;
            end
        endcase
    end

    // Datapath and registered outputs; reset drops any word in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            w       <= w_nxt;
            w_valid <= w_valid_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Purpose: directed bench for serial_pattern_tx in MSB-first, LSB-first and zero-gap builds.
// Latency: expects first bit one cycle after load and ready again WIDTH+GAP+1 cycles later.
// Backpressure: exercises loads issued while busy, which must be ignored.
module tb_serial_pattern_tx;

    logic       Clock = 1'b0;
    logic       Resetn;

    logic [7:0] d_msb, d_lsb, d_b2b;
    logic       ld_msb, ld_lsb, ld_b2b;
    logic       rdy_msb, w_msb, wv_msb, dn_msb;
    logic       rdy_lsb, w_lsb, wv_lsb, dn_lsb;
    logic       rdy_b2b, w_b2b, wv_b2b, dn_b2b;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    serial_pattern_tx #(.WIDTH(8), .GAP(2), .LSB_FIRST(1'b0)) u_msb (
        .Clock(Clock), .Resetn(Resetn), .data_in(d_msb), .load(ld_msb),
        .ready(rdy_msb), .w(w_msb), .w_valid(wv_msb), .done(dn_msb)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(2), .LSB_FIRST(1'b1)) u_lsb (
        .Clock(Clock), .Resetn(Resetn), .data_in(d_lsb), .load(ld_lsb),
        .ready(rdy_lsb), .w(w_lsb), .w_valid(wv_lsb), .done(dn_lsb)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0), .LSB_FIRST(1'b0)) u_b2b (
        .Clock(Clock), .Resetn(Resetn), .data_in(d_b2b), .load(ld_b2b),
        .ready(rdy_b2b), .w(w_b2b), .w_valid(wv_b2b), .done(dn_b2b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One MSB-first word on u_msb; a load of 8'hFF is pulsed in poke_cycle (0 = none).
    task automatic run_msb(input logic [7:0] data, input int poke_cycle, input string name);
        logic [7:0] dv;
        dv     = data;
        d_msb  = data;
        ld_msb = 1'b1;
        check_val({name, " c0 ready"}, 32'(rdy_msb), 32'd1);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) ld_msb = 1'b0;
            if (c <= 8) begin
                check_val($sformatf("%s c%0d w", name, c), 32'(w_msb), 32'(dv[8-c]));
                check_val($sformatf("%s c%0d w_valid", name, c), 32'(wv_msb), 32'd1);
            end else begin
                check_val($sformatf("%s c%0d w", name, c), 32'(w_msb), 32'd0);
                check_val($sformatf("%s c%0d w_valid", name, c), 32'(wv_msb), 32'd0);
            end
            check_val($sformatf("%s c%0d done", name, c), 32'(dn_msb), 32'(c == 8));
            check_val($sformatf("%s c%0d ready", name, c), 32'(rdy_msb), 32'(c == 11));
            if (c == poke_cycle) begin
                d_msb  = 8'hFF;
                ld_msb = 1'b1;
            end else if (c == poke_cycle + 1) begin
                ld_msb = 1'b0;
            end
        end
        tick();
        check_val({name, " after w_valid"}, 32'(wv_msb), 32'd0);
    endtask

    initial begin
        logic [7:0] dv;
        Resetn = 1'b0;
        d_msb = 8'h00; d_lsb = 8'h00; d_b2b = 8'h00;
        ld_msb = 1'b0; ld_lsb = 1'b0; ld_b2b = 1'b0;
        #1;
        check_val("rst w", 32'(w_msb), 32'd0);
        check_val("rst w_valid", 32'(wv_msb), 32'd0);
        check_val("rst done", 32'(dn_msb), 32'd0);
        check_val("rst ready", 32'(rdy_msb), 32'd1);
        check_val("rst lsb ready", 32'(rdy_lsb), 32'd1);
        check_val("rst b2b ready", 32'(rdy_b2b), 32'd1);
        #20;
        @(negedge Clock);
        Resetn = 1'b1;
        tick();

        // Plain A5, then A5 with an ignored FF load mid-word.
        run_msb(8'hA5, 0, "a5");
        run_msb(8'hA5, 4, "busy");

        // LSB-first single word.
        dv     = 8'h01;
        d_lsb  = dv;
        ld_lsb = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) ld_lsb = 1'b0;
            if (c <= 8) begin
                check_val($sformatf("lsb c%0d w", c), 32'(w_lsb), 32'(dv[c-1]));
                check_val($sformatf("lsb c%0d w_valid", c), 32'(wv_lsb), 32'd1);
            end
            check_val($sformatf("lsb c%0d done", c), 32'(dn_lsb), 32'(c == 8));
            if (c >= 9) check_val($sformatf("lsb c%0d ready", c), 32'(rdy_lsb), 32'(c == 11));
        end

        // Back-to-back with GAP=0 and load held high; data_in changes mid-word.
        d_b2b  = 8'hC3;
        ld_b2b = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 1) d_b2b = 8'h3C;
            if (c <= 8) begin
                dv = 8'hC3;
                check_val($sformatf("b2b c%0d w", c), 32'(w_b2b), 32'(dv[8-c]));
                check_val($sformatf("b2b c%0d w_valid", c), 32'(wv_b2b), 32'd1);
            end else if (c == 9) begin
                check_val("b2b c9 w_valid", 32'(wv_b2b), 32'd0);
                check_val("b2b c9 w", 32'(w_b2b), 32'd0);
                check_val("b2b c9 ready", 32'(rdy_b2b), 32'd1);
            end else begin
                dv = 8'h3C;
                check_val($sformatf("b2b c%0d w", c), 32'(w_b2b), 32'(dv[17-c]));
                check_val($sformatf("b2b c%0d w_valid", c), 32'(wv_b2b), 32'd1);
            end
            check_val($sformatf("b2b c%0d done", c), 32'(dn_b2b), 32'(c == 8 || c == 17));
        end
        ld_b2b = 1'b0;
        tick();
        check_val("b2b c18 w_valid", 32'(wv_b2b), 32'd0);
        tick();

        // Reset in the middle of cycle 4 of A5: outputs clear without a clock edge.
        d_msb  = 8'hA5;
        ld_msb = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) ld_msb = 1'b0;
            check_val($sformatf("mid c%0d w", c), 32'(w_msb), 32'(d_msb[8-c]));
        end
        #2;
        Resetn = 1'b0;
        #1;
        check_val("mid rst w", 32'(w_msb), 32'd0);
        check_val("mid rst w_valid", 32'(wv_msb), 32'd0);
        check_val("mid rst done", 32'(dn_msb), 32'd0);
        check_val("mid rst ready", 32'(rdy_msb), 32'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_val($sformatf("in rst %0d done", c), 32'(dn_msb), 32'd0);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        dv     = 8'h5A;
        d_msb  = dv;
        ld_msb = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) ld_msb = 1'b0;
            if (c <= 8) begin
                check_val($sformatf("post c%0d w", c), 32'(w_msb), 32'(dv[8-c]));
                check_val($sformatf("post c%0d w_valid", c), 32'(wv_msb), 32'd1);
            end else begin
                check_val("post c9 w_valid", 32'(wv_msb), 32'd0);
            end
            check_val($sformatf("post c%0d done", c), 32'(dn_msb), 32'(c == 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
